i2c_adc_scan: RTL and testbench

I2C_ADC_SCAN -- requirements
Module: i2c_adc_scan

---
 rtl/i2c_adc_scan.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_i2c_adc_scan.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_adc_scan.sv
// ---------------------------------------------------------------------------
// i2c_adc_scan
// Scans a set of ADC channels over an I2C byte engine. For each enabled
// channel it writes the channel-select config byte, then reads back a 16-bit
// word and reports the DATA_W-bit field at LSB_POS. A slave NACK during the
// address/config phase aborts that channel with a STOP and an err strobe.
// Optionally repeats the scan after SCAN_GAP idle cycles.
//
// Ports
//   sys_clk, sys_rst     clock, asynchronous active-high reset
//   start                one-cycle scan request (ignored while busy or mask=0)
//   cont_en              level; repeat scans while high
//   ch_mask[NUM_CH]      channel enable mask, latched at scan start
//   busy                 scan in progress
//   res_data/res_ch      conversion result and its channel, qualified by res_vld
//   err/err_ch           one-cycle NACK strobe and the offending channel
//   i2c_cmd/_vld/_wr_data  command to the byte engine
//   i2c_rd_data/_done/_nack response from the byte engine
// ---------------------------------------------------------------------------
module i2c_adc_scan #(
    parameter int         NUM_CH   = 4,
    parameter int         DATA_W   = 12,
    parameter int         LSB_POS  = 4,
    parameter logic [6:0] DEV_ID   = 7'h48,
    parameter logic [7:0] PTR_ADDR = 8'h01,
    parameter logic [7:0] CH_BASE  = 8'h40,
    parameter int         SCAN_GAP = 1000,
    localparam int        CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              cont_en,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              busy,
    output logic [DATA_W-1:0] res_data,
    output logic [CH_W-1:0]   res_ch,
    output logic              res_vld,
    output logic              err,
    output logic [CH_W-1:0]   err_ch,
    output logic [4:0]        i2c_cmd,
    output logic              i2c_cmd_vld,
    output logic [7:0]        i2c_wr_data,
    input  logic [7:0]        i2c_rd_data,
    input  logic              i2c_done,
    input  logic              i2c_nack
);

    localparam logic [4:0] CMD_START = 5'b00001;
    localparam logic [4:0] CMD_WRITE = 5'b00010;
    localparam logic [4:0] CMD_READ  = 5'b00100;
    localparam logic [4:0] CMD_STOP  = 5'b01000;
    localparam logic [4:0] CMD_ACK   = 5'b10000;

    localparam int              GAP_W    = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, ABORT, GAP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NUM_CH-1:0]   r_mask;
    logic [CH_W-1:0]     r_ch;
    logic [2:0]          r_b;
    logic [7:0]          r_hi;
    logic [7:0]          r_lo;
    logic [GAP_W-1:0]    r_gap_cnt;

    logic                r_busy;
    logic [DATA_W-1:0]   r_res_data;
    logic [CH_W-1:0]     r_res_ch;
    logic                r_res_vld;
    logic                r_err;
    logic [CH_W-1:0]     r_err_ch;
    logic [4:0]          r_cmd;
    logic                r_cmd_vld;
    logic [7:0]          r_wr_data;

    logic                w_first_found;
    logic [CH_W-1:0]     w_first_ch;
    logic                w_next_found;
    logic [CH_W-1:0]     w_next_ch;
    logic [4:0]          w_cmd;
    logic [7:0]          w_wr_data;
    logic                w_nack_abort;

    // Result field extraction from the assembled {hi, lo} read word.
    function automatic logic [DATA_W-1:0] f_extract(input logic [15:0] word);
        return word[LSB_POS +: DATA_W];
    endfunction

    assign busy        = r_busy;
    assign res_data    = r_res_data;
    assign res_ch      = r_res_ch;
    assign res_vld     = r_res_vld;
    assign err         = r_err;
    assign err_ch      = r_err_ch;
    assign i2c_cmd     = r_cmd;
    assign i2c_cmd_vld = r_cmd_vld;
    assign i2c_wr_data = r_wr_data;

    // NACKs only abort during the address/config bytes; read-phase NACKs are
    // treated as normal completions.
    assign w_nack_abort = i2c_nack && (r_b <= 3'd3);

    // Lowest set bit of the live mask (scan start / rescan after the gap) and
    // lowest set bit of the latched mask strictly above the current channel.
    // Descending loops so the last hit is the lowest index.
    always_comb begin
        w_first_found = 1'b0;
        w_first_ch    = '0;
        w_next_found  = 1'b0;
        w_next_ch     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                w_first_found = 1'b1;
                w_first_ch    = i[CH_W-1:0];
            end
            if (r_mask[i] && (i > int'(r_ch))) begin
                w_next_found = 1'b1;
                w_next_ch    = i[CH_W-1:0];
            end
        end
    end

    // Command and write byte for the current byte index.
    always_comb begin
        w_cmd     = CMD_READ | CMD_STOP;
        w_wr_data = 8'h00;
        case (r_b)
            3'd0: begin
                w_cmd     = CMD_START | CMD_WRITE;
                w_wr_data = {DEV_ID, 1'b0};
            end
            3'd1: begin
                w_cmd     = CMD_WRITE;
                w_wr_data = PTR_ADDR;
            end
            3'd2: begin
                w_cmd     = CMD_WRITE | CMD_STOP;
                w_wr_data = CH_BASE | {{(8-CH_W){1'b0}}, r_ch};
            end
            3'd3: begin
                w_cmd     = CMD_START | CMD_WRITE;
                w_wr_data = {DEV_ID, 1'b1};
            end
            3'd4: begin
                w_cmd     = CMD_READ | CMD_ACK;
                w_wr_data = 8'h00;
            end
            default: begin
                w_cmd     = CMD_READ | CMD_STOP;
                w_wr_data = 8'h00;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && (|ch_mask)) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (i2c_done) begin
                    if (w_nack_abort) begin
                        w_state_nxt = ABORT;
                    end else if (r_b == 3'd5) begin
                        w_state_nxt = NEXT;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ABORT: begin
                if (i2c_done) begin
                    w_state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (w_next_found) begin
                    w_state_nxt = ISSUE;
                end else if (cont_en) begin
                    w_state_nxt = GAP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GAP: begin
                if (!cont_en) begin
                    w_state_nxt = IDLE;
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = w_first_found ? ISSUE : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_mask     <= '0;
            r_ch       <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_gap_cnt  <= '0;
            r_busy     <= 1'b0;
            r_res_data <= '0;
            r_res_ch   <= '0;
            r_res_vld  <= 1'b0;
            r_err      <= 1'b0;
            r_err_ch   <= '0;
            r_cmd      <= '0;
            r_cmd_vld  <= 1'b0;
            r_wr_data  <= '0;
        end else begin
            r_res_vld <= 1'b0;
            r_err     <= 1'b0;
            r_cmd_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && (|ch_mask)) begin
                        r_mask <= ch_mask;
                        r_ch   <= w_first_ch;
                        r_b    <= '0;
                        r_busy <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_cmd_vld <= 1'b1;
                    r_cmd     <= w_cmd;
                    r_wr_data <= w_wr_data;
                end
                WAIT: begin
                    if (i2c_done) begin
                        if (w_nack_abort) begin
                            // The STOP goes out on the same edge as err; the
                            // NACKed command is already complete.
                            r_err     <= 1'b1;
                            r_err_ch  <= r_ch;
                            r_cmd_vld <= 1'b1;
                            r_cmd     <= CMD_STOP;
                            r_wr_data <= 8'h00;
                        end else if (r_b == 3'd5) begin
                            // Low byte arrives now, so build the result from
                            // the live read data rather than waiting for r_lo.
                            r_lo       <= i2c_rd_data;
                            r_res_vld  <= 1'b1;
                            r_res_data <= f_extract({r_hi, i2c_rd_data});
                            r_res_ch   <= r_ch;
                        end else begin
                            if (r_b == 3'd4) begin
                                r_hi <= i2c_rd_data;
                            end
                            r_b <= r_b + 3'd1;
                        end
                    end
                end
                NEXT: begin
                    r_gap_cnt <= '0;
                    if (w_next_found) begin
                        r_ch <= w_next_ch;
                        r_b  <= '0;
                    end else if (!cont_en) begin
                        r_busy <= 1'b0;
                    end
                end
                GAP: begin
                    if (!cont_en) begin
                        r_busy <= 1'b0;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        if (w_first_found) begin
                            r_mask <= ch_mask;
                            r_ch   <= w_first_ch;
                            r_b    <= '0;
                        end else begin
                            r_busy <= 1'b0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_adc_scan.sv
// ---------------------------------------------------------------------------
// tb_i2c_adc_scan
// Bench for i2c_adc_scan. A byte-engine model answers every command; a
// negedge monitor pops expected commands, results and errors from queues
// filled by the scenario tasks. A second instance covers DATA_W=16,
// LSB_POS=0, NUM_CH=1.
// ---------------------------------------------------------------------------
module tb_i2c_adc_scan;

    typedef struct {
        logic [4:0] cmd;
        logic [7:0] data;
        bit         chk;
    } cmd_t;

    typedef struct {
        logic [11:0] data;
        logic [1:0]  ch;
    } res_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start   = 1'b0;
    logic        cont_en = 1'b0;
    logic [3:0]  ch_mask = 4'b0000;
    logic        busy;
    logic [11:0] res_data;
    logic [1:0]  res_ch;
    logic        res_vld;
    logic        err;
    logic [1:0]  err_ch;
    logic [4:0]  i2c_cmd;
    logic        i2c_cmd_vld;
    logic [7:0]  i2c_wr_data;
    logic [7:0]  i2c_rd_data = 8'h00;
    logic        i2c_done    = 1'b0;
    logic        i2c_nack    = 1'b0;

    logic        start2 = 1'b0;
    logic        cont2  = 1'b0;
    logic [0:0]  mask2  = 1'b0;
    logic        busy2;
    logic [15:0] res_data2;
    logic [0:0]  res_ch2;
    logic        res_vld2;
    logic        err2;
    logic [0:0]  err_ch2;
    logic [4:0]  cmd2;
    logic        cmd_vld2;
    logic [7:0]  wr2;
    logic [7:0]  rd2   = 8'h00;
    logic        done2 = 1'b0;
    logic        nack2 = 1'b0;

    int   errors  = 0;
    int   checks  = 0;
    int   cmd_cnt = 0;
    int   res_cnt = 0;
    int   nack_arm = -1;
    bit   outstanding = 1'b0;

    cmd_t exp_cmd_q[$];
    res_t exp_res_q[$];
    logic [1:0] exp_err_q[$];

    cmd_t mon_c;
    res_t mon_r;
    logic [1:0] mon_e;
    logic [4:0] eng_cmd;

    always #5 sys_clk = ~sys_clk;

    i2c_adc_scan #(.SCAN_GAP(5)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .cont_en(cont_en),
        .ch_mask(ch_mask), .busy(busy), .res_data(res_data), .res_ch(res_ch),
        .res_vld(res_vld), .err(err), .err_ch(err_ch), .i2c_cmd(i2c_cmd),
        .i2c_cmd_vld(i2c_cmd_vld), .i2c_wr_data(i2c_wr_data),
        .i2c_rd_data(i2c_rd_data), .i2c_done(i2c_done), .i2c_nack(i2c_nack)
    );

    i2c_adc_scan #(.DATA_W(16), .LSB_POS(0), .NUM_CH(1), .SCAN_GAP(5)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start2), .cont_en(cont2),
        .ch_mask(mask2), .busy(busy2), .res_data(res_data2), .res_ch(res_ch2),
        .res_vld(res_vld2), .err(err2), .err_ch(err_ch2), .i2c_cmd(cmd2),
        .i2c_cmd_vld(cmd_vld2), .i2c_wr_data(wr2),
        .i2c_rd_data(rd2), .i2c_done(done2), .i2c_nack(nack2)
    );

    // Byte-engine model: answers each command two cycles later.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (i2c_cmd_vld === 1'b1) begin
                eng_cmd = i2c_cmd;
                repeat (2) @(posedge sys_clk);
                #1;
                if (eng_cmd == 5'b10100)      i2c_rd_data = 8'hAB;
                else if (eng_cmd == 5'b01100) i2c_rd_data = 8'hCD;
                else                          i2c_rd_data = 8'h00;
                i2c_nack = (nack_arm == 0);
                if (nack_arm >= 0) nack_arm = nack_arm - 1;
                i2c_done = 1'b1;
                @(posedge sys_clk);
                #1;
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            outstanding = 1'b0;
        end else begin
            if (i2c_done === 1'b1) outstanding = 1'b0;
            if (i2c_cmd_vld === 1'b1) begin
                cmd_cnt++;
                checks++;
                if (outstanding) begin
                    errors++;
                    $display("FAIL cmd_overlap: command issued before previous done (cmd=%b)", i2c_cmd);
                end
                outstanding = 1'b1;
                checks++;
                if (exp_cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected: got cmd=%b data=%h, expected none", i2c_cmd, i2c_wr_data);
                end else begin
                    mon_c = exp_cmd_q.pop_front();
                    if (i2c_cmd !== mon_c.cmd || (mon_c.chk && i2c_wr_data !== mon_c.data)) begin
                        errors++;
                        $display("FAIL cmd_seq: got cmd=%b data=%h, expected cmd=%b data=%h",
                                 i2c_cmd, i2c_wr_data, mon_c.cmd, mon_c.data);
                    end
                end
            end
            if (res_vld === 1'b1) begin
                res_cnt++;
                checks++;
                if (exp_res_q.size() == 0) begin
                    errors++;
                    $display("FAIL res_unexpected: got data=%h ch=%0d, expected none", res_data, res_ch);
                end else begin
                    mon_r = exp_res_q.pop_front();
                    if (res_data !== mon_r.data || res_ch !== mon_r.ch) begin
                        errors++;
                        $display("FAIL res: got data=%h ch=%0d, expected data=%h ch=%0d",
                                 res_data, res_ch, mon_r.data, mon_r.ch);
                    end
                end
            end
            if (err === 1'b1) begin
                checks++;
                if (exp_err_q.size() == 0) begin
                    errors++;
                    $display("FAIL err_unexpected: got err_ch=%0d, expected none", err_ch);
                end else begin
                    mon_e = exp_err_q.pop_front();
                    if (err_ch !== mon_e) begin
                        errors++;
                        $display("FAIL err_ch: got %0d, expected %0d", err_ch, mon_e);
                    end
                end
            end
            if (err === 1'b1 && res_vld === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL err_res_overlap: err=%b res_vld=%b, expected not both", err, res_vld);
            end
        end
    end

    // Expected command stream for channel c, first n byte indices.
    task automatic push_channel(input int c, input int n);
        cmd_t seq[6];
        seq[0] = '{5'b00011, 8'h90, 1'b1};
        seq[1] = '{5'b00010, 8'h01, 1'b1};
        seq[2] = '{5'b01010, 8'h40 | 8'(c), 1'b1};
        seq[3] = '{5'b00011, 8'h91, 1'b1};
        seq[4] = '{5'b10100, 8'h00, 1'b0};
        seq[5] = '{5'b01100, 8'h00, 1'b0};
        for (int i = 0; i < n; i++) exp_cmd_q.push_back(seq[i]);
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({busy, res_vld, err, i2c_cmd_vld} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 0000", {busy, res_vld, err, i2c_cmd_vld});
        end
        checks++;
        if ({res_data, res_ch, err_ch, i2c_cmd, i2c_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got res=%h ch=%0d ech=%0d cmd=%b wd=%h, expected all 0",
                     res_data, res_ch, err_ch, i2c_cmd, i2c_wr_data);
        end
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        checks++;
        if (cmd_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_cmd: got %0d commands, expected 0", cmd_cnt);
        end
    endtask

    task automatic test_basic_scan();
        ch_mask = 4'b0101;
        push_channel(0, 6);
        exp_res_q.push_back('{12'hABC, 2'd0});
        push_channel(2, 6);
        exp_res_q.push_back('{12'hABC, 2'd2});
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b, expected 1", busy);
        end
        for (int k = 0; k < 600 && busy !== 1'b0; k++) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || exp_cmd_q.size() != 0 || exp_res_q.size() != 0) begin
            errors++;
            $display("FAIL basic_end: busy=%b cmds_left=%0d res_left=%0d, expected 0 0 0",
                     busy, exp_cmd_q.size(), exp_res_q.size());
        end
    endtask

    task automatic test_zero_mask();
        int base;
        base = cmd_cnt;
        ch_mask = 4'b0000;
        pulse_start();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_mask_busy: got %b, expected 0", busy);
        end
        repeat (10) @(negedge sys_clk);
        checks++;
        if (cmd_cnt != base) begin
            errors++;
            $display("FAIL zero_mask_cmd: got %0d commands, expected 0", cmd_cnt - base);
        end
    endtask

    task automatic test_start_while_busy();
        ch_mask = 4'b0001;
        push_channel(0, 6);
        exp_res_q.push_back('{12'hABC, 2'd0});
        pulse_start();
        repeat (4) @(negedge sys_clk);
        ch_mask = 4'b1111;
        pulse_start();
        for (int k = 0; k < 600 && busy !== 1'b0; k++) @(negedge sys_clk);
        repeat (10) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || exp_cmd_q.size() != 0 || exp_res_q.size() != 0) begin
            errors++;
            $display("FAIL busy_start: busy=%b cmds_left=%0d res_left=%0d, expected 0 0 0",
                     busy, exp_cmd_q.size(), exp_res_q.size());
        end
    endtask

    task automatic test_nack();
        int rbase;
        rbase = res_cnt;
        ch_mask = 4'b0010;
        exp_cmd_q.push_back('{5'b00011, 8'h90, 1'b1});
        exp_cmd_q.push_back('{5'b01000, 8'h00, 1'b1});
        exp_err_q.push_back(2'd1);
        nack_arm = 0;
        pulse_start();
        for (int k = 0; k < 300 && busy !== 1'b0; k++) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || exp_cmd_q.size() != 0 || exp_err_q.size() != 0) begin
            errors++;
            $display("FAIL nack_end: busy=%b cmds_left=%0d errs_left=%0d, expected 0 0 0",
                     busy, exp_cmd_q.size(), exp_err_q.size());
        end
        checks++;
        if (res_cnt != rbase) begin
            errors++;
            $display("FAIL nack_no_res: got %0d results, expected 0", res_cnt - rbase);
        end
        nack_arm = -1;
    endtask

    task automatic test_nack_read();
        ch_mask = 4'b0001;
        push_channel(0, 6);
        exp_res_q.push_back('{12'hABC, 2'd0});
        nack_arm = 4;
        pulse_start();
        for (int k = 0; k < 300 && busy !== 1'b0; k++) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || exp_cmd_q.size() != 0 || exp_res_q.size() != 0) begin
            errors++;
            $display("FAIL nack_read: busy=%b cmds_left=%0d res_left=%0d, expected 0 0 0",
                     busy, exp_cmd_q.size(), exp_res_q.size());
        end
        nack_arm = -1;
    endtask

    task automatic test_continuous();
        int n;
        bit seen;
        cont_en = 1'b1;
        ch_mask = 4'b1000;
        for (int s = 0; s < 2; s++) begin
            push_channel(3, 6);
            exp_res_q.push_back('{12'hABC, 2'd3});
        end
        pulse_start();
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge sys_clk);
            if (res_vld === 1'b1) seen = 1'b1;
        end
        n = 0;
        for (int k = 0; k < 100 && i2c_cmd_vld !== 1'b1; k++) begin
            @(negedge sys_clk);
            n++;
        end
        // n counts from the result strobe, one cycle after the last done.
        checks++;
        if (!seen || i2c_cmd_vld !== 1'b1 || (n + 1) < 5) begin
            errors++;
            $display("FAIL cont_gap: seen_res=%b cmd_vld=%b gap=%0d, expected gap >= 5", seen, i2c_cmd_vld, n + 1);
        end
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge sys_clk);
            if (res_vld === 1'b1) seen = 1'b1;
        end
        @(negedge sys_clk);
        cont_en = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (!seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop: seen_res=%b busy=%b, expected 1 0", seen, busy);
        end
        repeat (10) @(negedge sys_clk);
        checks++;
        if (exp_cmd_q.size() != 0 || exp_res_q.size() != 0) begin
            errors++;
            $display("FAIL cont_end: cmds_left=%0d res_left=%0d, expected 0 0", exp_cmd_q.size(), exp_res_q.size());
        end
    endtask

    task automatic test_reset_midtransfer();
        int n;
        int base;
        ch_mask = 4'b0001;
        push_channel(0, 4);
        pulse_start();
        n = 0;
        for (int k = 0; k < 300 && n < 4; k++) begin
            @(negedge sys_clk);
            if (i2c_cmd_vld === 1'b1) n++;
        end
        #2;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (n != 4 || {busy, res_vld, err, i2c_cmd_vld} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_ctrl: cmds=%0d ctrl=%b, expected 4 and 0000", n, {busy, res_vld, err, i2c_cmd_vld});
        end
        checks++;
        if ({res_data, res_ch, err_ch, i2c_cmd, i2c_wr_data} !== '0) begin
            errors++;
            $display("FAIL rst_mid_data: got res=%h ch=%0d ech=%0d cmd=%b wd=%h, expected all 0",
                     res_data, res_ch, err_ch, i2c_cmd, i2c_wr_data);
        end
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        base = cmd_cnt;
        repeat (20) @(negedge sys_clk);
        checks++;
        if (cmd_cnt != base || busy !== 1'b0 || exp_cmd_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: new_cmds=%0d busy=%b cmds_left=%0d, expected 0 0 0",
                     cmd_cnt - base, busy, exp_cmd_q.size());
        end
    endtask

    task automatic test_param_sweep();
        int ncmd;
        int nres;
        logic [4:0] c2;
        ncmd = 0;
        nres = 0;
        mask2 = 1'b1;
        @(negedge sys_clk);
        start2 = 1'b1;
        @(negedge sys_clk);
        start2 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge sys_clk);
            if (res_vld2 === 1'b1) begin
                nres++;
                checks++;
                if (res_data2 !== 16'hABCD || res_ch2 !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_res: got data=%h ch=%0d, expected data=abcd ch=0", res_data2, res_ch2);
                end
            end
            if (cmd_vld2 === 1'b1) begin
                ncmd++;
                c2 = cmd2;
                @(posedge sys_clk);
                #1;
                rd2 = (c2 == 5'b10100) ? 8'hAB : ((c2 == 5'b01100) ? 8'hCD : 8'h00);
                done2 = 1'b1;
                @(posedge sys_clk);
                #1;
                done2 = 1'b0;
            end else if (busy2 !== 1'b1) begin
                break;
            end
        end
        checks++;
        if (ncmd != 6 || nres != 1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end: cmds=%0d results=%0d busy=%b, expected 6 1 0", ncmd, nres, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_zero_mask();
        test_start_while_busy();
        test_nack();
        test_nack_read();
        test_continuous();
        test_reset_midtransfer();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
